// File: rtl/instruction_fetch.sv
// instruction_fetch: paces program_counter, latches the fetched word, offers it downstream.
// Optional macro INSTRUCTION_FETCH_SINGLE_STEP_EN adds i_step and a STEP state.
module instruction_fetch #(
    parameter int unsigned FETCH_LATENCY    = 2,
    parameter logic [3:0]  HALT_OPCODE      = 4'hF,
    parameter logic [15:0] FETCH_COUNT_INIT = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_instruction,
    output logic        o_inc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_instr,
    output logic [3:0]  o_opcode,
    output logic [1:0]  o_rd,
    output logic [1:0]  o_rs,
    output logic [7:0]  o_imm,
    output logic        o_halted,
`ifdef INSTRUCTION_FETCH_SINGLE_STEP_EN
    input  logic        i_step,
`endif
    output logic [15:0] o_fetch_count
);

    localparam logic [3:0] LAT = 4'(FETCH_LATENCY);

    typedef enum logic [2:0] {
        S_WAIT,
        S_HOLD,
        S_ISSUE,
`ifdef INSTRUCTION_FETCH_SINGLE_STEP_EN
        S_STEP,
`endif
        S_HALTED
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] ir_q;
    logic        valid_q;
    logic        inc_q;
    logic        halted_q;
    logic [15:0] count_q;

    // Fetch FSM; o_inc is set only on entry to ISSUE so it is a clean registered pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_WAIT;
            cnt_q    <= LAT;
            ir_q     <= 16'h0000;
            valid_q  <= 1'b0;
            inc_q    <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= FETCH_COUNT_INIT;
        end else begin
            inc_q <= 1'b0;
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        ir_q    <= i_instruction;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        count_q <= count_q + 16'd1;
                        if (ir_q[15:12] == HALT_OPCODE) begin
                            state_q  <= S_HALTED;
                            halted_q <= 1'b1;
                        end else begin
`ifdef INSTRUCTION_FETCH_SINGLE_STEP_EN
                            state_q <= S_STEP;
`else
                            state_q <= S_ISSUE;
                            inc_q   <= 1'b1;
`endif
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= LAT;
                    state_q <= S_WAIT;
                end
`ifdef INSTRUCTION_FETCH_SINGLE_STEP_EN
                S_STEP: begin
                    if (i_step) begin
                        state_q <= S_ISSUE;
                        inc_q   <= 1'b1;
                    end
                end
`endif
                S_HALTED: begin
                    halted_q <= 1'b1;
                    valid_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_WAIT;
                    cnt_q   <= LAT;
                end
            endcase
        end
    end

    assign o_inc         = inc_q;
    assign o_valid       = valid_q;
    assign o_instr       = ir_q;
    assign o_opcode      = ir_q[15:12];
    assign o_rd          = ir_q[11:10];
    assign o_rs          = ir_q[9:8];
    assign o_imm         = ir_q[7:0];
    assign o_halted      = halted_q;
    assign o_fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch.
// Directed program in a small memory model behind a program_counter model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic        step;
    logic [15:0] instr_in;
    logic        o_inc, o_valid, o_halted;
    logic [15:0] o_instr, o_fetch_count;
    logic [3:0]  o_opcode;
    logic [1:0]  o_rd, o_rs;
    logic [7:0]  o_imm;

    logic        w_ready;
    logic        w_inc, w_valid, w_halted;
    logic [15:0] w_instr, w_count;
    logic [3:0]  w_opcode;
    logic [1:0]  w_rd, w_rs;
    logic [7:0]  w_imm;

    logic [15:0] mem [0:15];
    logic [3:0]  addr;
    logic        pc_load;
    logic [3:0]  pc_val;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  op;
        logic [1:0]  rd;
        logic [1:0]  rs;
        logic [7:0]  imm;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic        pend = 1'b0;
    logic [15:0] pend_cnt = 16'h0;

    always #5 clk = ~clk;

    instruction_fetch #(.FETCH_LATENCY(2), .HALT_OPCODE(4'hF)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_instruction(instr_in),
        .o_inc(o_inc), .o_valid(o_valid), .i_ready(ready),
        .o_instr(o_instr), .o_opcode(o_opcode), .o_rd(o_rd),
        .o_rs(o_rs), .o_imm(o_imm), .o_halted(o_halted),
`ifdef INSTRUCTION_FETCH_SINGLE_STEP_EN
        .i_step(step),
`endif
        .o_fetch_count(o_fetch_count)
    );

    instruction_fetch #(
        .FETCH_LATENCY(2), .HALT_OPCODE(4'hF), .FETCH_COUNT_INIT(16'hFFFF)
    ) u_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_instruction(16'h1000),
        .o_inc(w_inc), .o_valid(w_valid), .i_ready(w_ready),
        .o_instr(w_instr), .o_opcode(w_opcode), .o_rd(w_rd),
        .o_rs(w_rs), .o_imm(w_imm), .o_halted(w_halted),
`ifdef INSTRUCTION_FETCH_SINGLE_STEP_EN
        .i_step(1'b0),
`endif
        .o_fetch_count(w_count)
    );

    assign instr_in = mem[addr];

    always @(posedge clk) begin
        if (pc_load) addr <= pc_val;
        else if (o_inc) addr <= addr + 4'd1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [15:0] i, input logic [3:0] op,
                        input logic [1:0] rd, input logic [1:0] rs,
                        input logic [7:0] imm, input logic [15:0] cnt);
        exp_t x;
        x.instr = i; x.op = op; x.rd = rd; x.rs = rs; x.imm = imm; x.cnt = cnt;
        sb.push_back(x);
    endtask

    // Monitor: pop expected word on every accept, check count one cycle later
    always begin
        @(negedge clk);
        #1;
        if (pend) begin
            chk("count_after_accept", 32'(o_fetch_count), 32'(pend_cnt));
            pend = 1'b0;
        end
        if (rst_n && o_valid && ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_accept: got 0x%0h, expected none", o_instr);
            end else begin
                e = sb.pop_front();
                chk("acc_instr", 32'(o_instr), 32'(e.instr));
                chk("acc_opcode", 32'(o_opcode), 32'(e.op));
                chk("acc_rd", 32'(o_rd), 32'(e.rd));
                chk("acc_rs", 32'(o_rs), 32'(e.rs));
                chk("acc_imm", 32'(o_imm), 32'(e.imm));
                pend = 1'b1;
                pend_cnt = e.cnt;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int n_inc;
        logic bad;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1234;
        mem[1] = 16'h2A5C;
        mem[2] = 16'hF000;
        mem[3] = 16'h3C81;
        mem[4] = 16'h4411;
        mem[5] = 16'hF000;
        mem[6] = 16'h5123;
        mem[7] = 16'h6000;

        rst_n = 1'b0; ready = 1'b1; step = 1'b0; w_ready = 1'b0;
        pc_load = 1'b1; pc_val = 4'd0;
        push(16'h1234, 4'h1, 2'd0, 2'd2, 8'h34, 16'd1);
        push(16'h2A5C, 4'h2, 2'd2, 2'd2, 8'h5C, 16'd2);
        push(16'hF000, 4'hF, 2'd0, 2'd0, 8'h00, 16'd3);
        push(16'h3C81, 4'h3, 2'd3, 2'd0, 8'h81, 16'd1);
        push(16'h4411, 4'h4, 2'd1, 2'd0, 8'h11, 16'd1);
        push(16'hF000, 4'hF, 2'd0, 2'd0, 8'h00, 16'd2);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_instr", 32'(o_instr), 32'h0);
        chk("reset_fields", 32'({o_opcode, o_rd, o_rs, o_imm}), 32'h0);
        chk("reset_flags", 32'({o_valid, o_inc, o_halted}), 32'h0);
        chk("reset_count", 32'(o_fetch_count), 32'h0);

        // free run: cycle 0 starts at release
        @(negedge clk);
        pc_load = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("c1_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        chk("c2_valid", 32'(o_valid), 32'd1);
        chk("c2_inc", 32'(o_inc), 32'd0);
        @(negedge clk);
        chk("c3_inc", 32'(o_inc), 32'd1);
        chk("c3_valid", 32'(o_valid), 32'd0);
        ready = 1'b0;
        @(negedge clk);
        chk("c4_inc", 32'(o_inc), 32'd0);

        // wrap instance has been holding 0x1000 since cycle 2
        chk("wrap_valid", 32'(w_valid), 32'd1);
        chk("wrap_pre", 32'(w_count), 32'hFFFF);
        w_ready = 1'b1;
        @(negedge clk);
        chk("wrap_post", 32'(w_count), 32'h0000);
        w_ready = 1'b0;

        // backpressure on the second word
        n = 0;
        while (!o_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_valid_rise", 32'(o_valid), 32'd1);
        bad = 1'b0;
        repeat (10) begin
            if (o_instr != 16'h2A5C || o_inc || !o_valid || o_fetch_count != 16'd1)
                bad = 1'b1;
            @(negedge clk);
        end
        chk("backpressure_stable", 32'(bad), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        chk("bp_release_inc", 32'(o_inc), 32'd1);
        chk("bp_release_valid", 32'(o_valid), 32'd0);

        // third word is HALT
        n = 0;
        while (!o_halted && n < 20) begin @(negedge clk); n++; end
        chk("halt_reached", 32'(o_halted), 32'd1);
        chk("halt_count", 32'(o_fetch_count), 32'd3);
        n_inc = 0;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (o_inc) n_inc++;
            if (!o_halted || o_valid) bad = 1'b1;
        end
        chk("halted_no_inc", 32'(n_inc), 32'd0);
        chk("halted_sticky", 32'(bad), 32'd0);

        // reset out of HALTED, then async reset in the middle of WAIT
        rst_n = 1'b0;
        pc_load = 1'b1;
        pc_val = 4'd3;
        #1;
        chk("rst_halt_clear", 32'({o_halted, o_valid, o_inc}), 32'h0);
        chk("rst_count_clear", 32'(o_fetch_count), 32'h0);
        @(negedge clk);
        pc_load = 1'b0;
        rst_n = 1'b1;
        n = 0;
        while (!o_inc && n < 20) begin @(negedge clk); n++; end
        chk("mid_inc_seen", 32'(o_inc), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_instr", 32'(o_instr), 32'h0);
        chk("mid_rst_flags", 32'({o_valid, o_inc, o_halted}), 32'h0);
        chk("mid_rst_count", 32'(o_fetch_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_c1_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        chk("mid_c2_valid", 32'(o_valid), 32'd1);
        n = 0;
        while (!o_halted && n < 20) begin @(negedge clk); n++; end
        chk("halt2_reached", 32'(o_halted), 32'd1);
        chk("halt2_count", 32'(o_fetch_count), 32'd2);

`ifdef INSTRUCTION_FETCH_SINGLE_STEP_EN
        push(16'h5123, 4'h5, 2'd0, 2'd1, 8'h23, 16'd1);
        rst_n = 1'b0;
        ready = 1'b0;
        pc_load = 1'b1;
        pc_val = 4'd6;
        @(negedge clk);
        pc_load = 1'b0;
        rst_n = 1'b1;
        n = 0;
        while (!o_valid && n < 20) begin @(negedge clk); n++; end
        chk("ss_valid", 32'(o_valid), 32'd1);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("ss_hold_step", 32'({o_valid, o_inc}), 32'h2);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("ss_accepted", 32'(o_valid), 32'd0);
        n_inc = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_inc) n_inc++;
        end
        chk("ss_no_inc", 32'(n_inc), 32'd0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("ss_step_inc", 32'(o_inc), 32'd1);
        @(negedge clk);
        chk("ss_inc_single", 32'(o_inc), 32'd0);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
